// File: rtl/mine_count_gen.sv
// Walks the active board one cell at a time and reads the 3x3 neighbourhood from the mine map.
// For each cell it writes the neighbour mine count, or 0 if the cell itself holds a mine.
module mine_count_gen #(
  parameter int COORD_W = 4,
  parameter int NUM_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         level,
  input  logic               start,
  output logic               mine_rd_en,
  output logic [COORD_W-1:0] mine_rd_x,
  output logic [COORD_W-1:0] mine_rd_y,
  input  logic               mine_rd_data,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [NUM_W-1:0]   wr_num,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W:0]   n_q, n_d;
  logic [3:0]         slot_q, slot_d;
  logic [NUM_W-1:0]   cnt_q, cnt_d;
  logic               self_q, self_d;
  logic               rd_prev_q;

  logic               rd_en_q, rd_en_d;
  logic [COORD_W-1:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic               wr_en_q, wr_en_d;
  logic [COORD_W-1:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [NUM_W-1:0]   wr_num_q, wr_num_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               sample;
  logic               last_x, last_y;
  logic [COORD_W:0]   nx, ny;

  assign sample = rd_prev_q & mine_rd_data;
  assign last_x = (x_q == COORD_W'(n_q - 1'b1));
  assign last_y = (y_q == COORD_W'(n_q - 1'b1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    n_d     = n_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    self_d  = self_q;
    case (state_q)
      IDLE: begin
        if (start && level != 2'd0) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
          slot_d  = '0;
          cnt_d   = '0;
          self_d  = 1'b0;
          case (level)
            2'd1:    n_d = (COORD_W+1)'(8);
            2'd2:    n_d = (COORD_W+1)'(10);
            default: n_d = (COORD_W+1)'(16);
          endcase
        end
      end
      SCAN: begin
        // Sample arriving in slot 5 belongs to the read of the cell itself (k=4).
        if (slot_q == 4'd5) self_d = self_q | sample;
        else                cnt_d  = cnt_q + NUM_W'(sample);
        if (slot_q == 4'd10) begin
          cnt_d  = '0;
          self_d = 1'b0;
          slot_d = '0;
          if (last_x && last_y) begin
            state_d = DONE;
          end else if (last_x) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values, so the read for slot k is on the pins during slot k.
  // The extra top bit turns -1 into a large value, so one unsigned compare rejects both -1 and N.
  always_comb begin
    nx       = {1'b0, x_d} + (COORD_W+1)'(slot_d % 4'd3) - (COORD_W+1)'(1);
    ny       = {1'b0, y_d} + (COORD_W+1)'(slot_d / 4'd3) - (COORD_W+1)'(1);
    rd_en_d  = (state_d == SCAN) && (slot_d <= 4'd8) && (nx < n_d) && (ny < n_d);
    rd_x_d   = rd_en_d ? nx[COORD_W-1:0] : '0;
    rd_y_d   = rd_en_d ? ny[COORD_W-1:0] : '0;
    wr_en_d  = (state_d == SCAN) && (slot_d == 4'd10);
    wr_x_d   = wr_en_d ? x_d : '0;
    wr_y_d   = wr_en_d ? y_d : '0;
    wr_num_d = (wr_en_d && !self_d) ? cnt_d : '0;
    busy_d   = (state_d == SCAN);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      n_q       <= '0;
      slot_q    <= '0;
      cnt_q     <= '0;
      self_q    <= 1'b0;
      rd_prev_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_num_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      n_q       <= n_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      self_q    <= self_d;
      rd_prev_q <= rd_en_q;
      rd_en_q   <= rd_en_d;
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
      wr_en_q   <= wr_en_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_num_q  <= wr_num_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mine_rd_en = rd_en_q;
  assign mine_rd_x  = rd_x_q;
  assign mine_rd_y  = rd_y_q;
  assign wr_en      = wr_en_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wr_num     = wr_num_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
